// File: rtl/aximm_gpio_csr_responder.sv
// AVMM CSR responder for the AXI-MM GPIO PHY harness: config/delay registers, status, capture readback.
// Optional: define CSR_UNMAPPED_ERR_EN for DEAD_BEEF unmapped reads and a W1C error flag at BUS_STS[31].
module aximm_gpio_csr_responder #(
  parameter int          DATA_WIDTH = 128,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h5000_0000
) (
  input  logic                  avmm_clk,
  input  logic                  avmm_rst_n,
  input  logic                  i_wren,
  input  logic                  i_rden,
  input  logic [31:0]           i_wr_addr,
  input  logic [31:0]           i_wrdata,
  output logic [31:0]           o_master_readdata,
  output logic                  o_master_readdatavalid,
  output logic                  o_master_waitrequest,
  input  logic [3:0]            i_linkup_sts,
  input  logic [3:0]            i_test_sts,
  input  logic                  i_wr_done,
  input  logic                  i_rd_done,
  input  logic [DATA_WIDTH-1:0] i_dout_first,
  input  logic [DATA_WIDTH-1:0] i_dout_last,
  input  logic [DATA_WIDTH-1:0] i_din_first,
  input  logic [DATA_WIDTH-1:0] i_din_last,
  output logic [31:0]           o_wr_cfg,
  output logic [31:0]           o_rd_cfg,
  output logic [31:0]           o_wr_rd_addr,
  output logic [31:0]           o_delay_x,
  output logic [31:0]           o_delay_y,
  output logic [31:0]           o_delay_z,
  output logic                  o_wr_start,
  output logic                  o_rd_start
);

  localparam logic [13:0] W_WR_CFG     = 14'h0400;
  localparam logic [13:0] W_WR_RD_ADDR = 14'h0401;
  localparam logic [13:0] W_BUS_STS    = 14'h0402;
  localparam logic [13:0] W_LINKUP_STS = 14'h0403;
  localparam logic [13:0] W_RD_CFG     = 14'h0404;
  localparam logic [13:0] W_DELAY_X    = 14'h0800;
  localparam logic [13:0] W_DELAY_Y    = 14'h0801;
  localparam logic [13:0] W_DELAY_Z    = 14'h0802;

`ifdef CSR_UNMAPPED_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
`endif

  logic              wren_q;
  logic              rden_q;
  logic              wr_acc;
  logic              rd_acc;
  logic              busy;
  logic              base_hit;
  logic [13:0]       woff;
  logic              mapped;
  logic [31:0]       rd_val;
  logic              wr_done_sts;
  logic              rd_done_sts;
  logic              err_sts;
  logic [RD_LATENCY-1:0] vld_p;
  logic [31:0]       rdat_p [RD_LATENCY];
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^i_wr_addr[1:0];

  assign base_hit = (i_wr_addr[31:16] == BASE_ADDR[31:16]);
  assign woff     = i_wr_addr[15:2];
  assign busy     = |vld_p;
  // Read edges that land while a read is outstanding are dropped, not queued.
  assign wr_acc   = i_wren & ~wren_q;
  assign rd_acc   = i_rden & ~rden_q & ~busy;

  assign o_master_waitrequest   = busy | rd_acc;
  assign o_master_readdatavalid = vld_p[RD_LATENCY-1];
  assign o_master_readdata      = rdat_p[RD_LATENCY-1];

  always_comb begin
    rd_val = '0;
    mapped = 1'b0;
    if (base_hit) begin
      mapped = 1'b1;
      case (woff)
        W_WR_CFG:     rd_val = o_wr_cfg;
        W_WR_RD_ADDR: rd_val = o_wr_rd_addr;
        W_BUS_STS:    rd_val = {err_sts, 25'd0, rd_done_sts, wr_done_sts, i_test_sts};
        W_LINKUP_STS: rd_val = {28'd0, i_linkup_sts};
        W_RD_CFG:     rd_val = o_rd_cfg;
        W_DELAY_X:    rd_val = o_delay_x;
        W_DELAY_Y:    rd_val = o_delay_y;
        W_DELAY_Z:    rd_val = o_delay_z;
        default: begin
          // 0x4000..0x403C: four capture ports, four words each, low word first.
          if (woff[13:4] == 10'h100) begin
            case (woff[3:2])
              2'd0:    rd_val = i_dout_first[{woff[1:0], 5'd0} +: 32];
              2'd1:    rd_val = i_dout_last[{woff[1:0], 5'd0} +: 32];
              2'd2:    rd_val = i_din_first[{woff[1:0], 5'd0} +: 32];
              default: rd_val = i_din_last[{woff[1:0], 5'd0} +: 32];
            endcase
          end else begin
            mapped = 1'b0;
          end
        end
      endcase
    end
    if (!mapped) rd_val = UNMAPPED_RDATA;
  end

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      o_wr_cfg     <= '0;
      o_rd_cfg     <= '0;
      o_wr_rd_addr <= '0;
      o_delay_x    <= '0;
      o_delay_y    <= '0;
      o_delay_z    <= '0;
      o_wr_start   <= 1'b0;
      o_rd_start   <= 1'b0;
      wr_done_sts  <= 1'b0;
      rd_done_sts  <= 1'b0;
    end else begin
      wren_q     <= i_wren;
      rden_q     <= i_rden;
      o_wr_start <= wr_acc & base_hit & (woff == W_WR_CFG);
      o_rd_start <= wr_acc & base_hit & (woff == W_RD_CFG);
      if (wr_acc && base_hit) begin
        case (woff)
          W_WR_CFG:     o_wr_cfg     <= i_wrdata;
          W_WR_RD_ADDR: o_wr_rd_addr <= i_wrdata;
          W_RD_CFG:     o_rd_cfg     <= i_wrdata;
          W_DELAY_X:    o_delay_x    <= i_wrdata;
          W_DELAY_Y:    o_delay_y    <= i_wrdata;
          W_DELAY_Z:    o_delay_z    <= i_wrdata;
          default: ;
        endcase
      end
      // The start pulse clears its sticky done bit and wins over a coincident set.
      if (o_wr_start)     wr_done_sts <= 1'b0;
      else if (i_wr_done) wr_done_sts <= 1'b1;
      if (o_rd_start)     rd_done_sts <= 1'b0;
      else if (i_rd_done) rd_done_sts <= 1'b1;
    end
  end

`ifdef CSR_UNMAPPED_ERR_EN
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      err_sts <= 1'b0;
    end else if (wr_acc && base_hit && (woff == W_BUS_STS) && i_wrdata[31]) begin
      err_sts <= 1'b0;
    end else if ((wr_acc || rd_acc) && !mapped) begin
      err_sts <= 1'b1;
    end
  end
`else
  assign err_sts = 1'b0;
`endif

  // Stage p0 captures the value in the accept cycle; later stages only move it forward.
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rdat_p[i] <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      if (rd_acc) rdat_p[0] <= rd_val;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) rdat_p[i] <= rdat_p[i-1];
      end
    end
  end

endmodule
